// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: fetch over a req/valid handshake, decode a 16-bit
// instruction, and sequence the datapath through EXECUTE and WRITEBACK.
module cpu_control_unit #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic              zero_flag,
    input  logic              pos_flag,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc,
    output logic              rf_write,
    output logic [2:0]        rs_addr,
    output logic [2:0]        rt_addr,
    output logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] imm_data,
    output logic [3:0]        alu_sel,
    output logic              imm_sel,
    output logic              mem_write,
    output logic              mem_sel,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000, OP_ADD  = 5'b00001, OP_SUB = 5'b00010,
                           OP_AND  = 5'b00011, OP_OR   = 5'b00100, OP_XOR = 5'b00101,
                           OP_ADDI = 5'b10000, OP_MOVI = 5'b10110, OP_LD  = 5'b11000,
                           OP_ST   = 5'b11001, OP_BZ   = 5'b11100, OP_BP  = 5'b11101,
                           OP_JMP  = 5'b11110, OP_HALT = 5'b11111;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_PASS_A = 4'b1010,
                           ALU_PASS_B = 4'b1011;

    state_t            state, next_state;
    logic [15:0]       ir, next_ir, dec_ir;
    logic              take, next_take;
    logic [PC_W-1:0]   next_pc, off_ext;

    logic [2:0]        d_rs, d_rt, d_rd;
    logic [DATA_W-1:0] d_imm;
    logic [3:0]        d_alu;
    logic              d_imm_sel, d_wr, d_ld, d_st, d_bz, d_bp, d_jmp, d_halt, d_illegal, d_noreg;

    logic              n_req, n_rf_write, n_imm_sel, n_mem_write, n_mem_sel, n_halted, n_illegal;
    logic [2:0]        n_rs, n_rt, n_rd;
    logic [DATA_W-1:0] n_imm;
    logic [3:0]        n_alu;

    // Decoding the incoming word while still in FETCH lets DECODE outputs be registered.
    assign dec_ir  = (state == FETCH) ? instr[15:0] : ir;
    assign off_ext = PC_W'($signed(ir[7:0]));

    // Instruction decoder: field extraction and per-opcode control attributes.
    always_comb begin
        d_rd      = dec_ir[10:8];
        d_rs      = dec_ir[7:5];
        d_rt      = dec_ir[4:2];
        d_imm     = '0;
        d_imm_sel = 1'b0;
        d_alu     = ALU_ADD;
        d_wr      = 1'b0;
        d_ld      = 1'b0;
        d_st      = 1'b0;
        d_bz      = 1'b0;
        d_bp      = 1'b0;
        d_jmp     = 1'b0;
        d_halt    = 1'b0;
        d_illegal = 1'b0;
        d_noreg   = 1'b0;
        case (dec_ir[15:11])
            OP_NOP:  d_noreg = 1'b1;
            OP_ADD:  d_wr = 1'b1;
            OP_SUB:  begin d_wr = 1'b1; d_alu = ALU_SUB; end
            OP_AND:  begin d_wr = 1'b1; d_alu = ALU_AND; end
            OP_OR:   begin d_wr = 1'b1; d_alu = ALU_OR;  end
            OP_XOR:  begin d_wr = 1'b1; d_alu = ALU_XOR; end
            OP_ADDI: begin
                d_wr = 1'b1; d_rs = dec_ir[10:8];
                d_imm = DATA_W'(dec_ir[7:0]); d_imm_sel = 1'b1;
            end
            OP_MOVI: begin
                d_wr = 1'b1; d_alu = ALU_PASS_B;
                d_imm = DATA_W'(dec_ir[7:0]); d_imm_sel = 1'b1;
            end
            OP_LD:   begin d_wr = 1'b1; d_ld = 1'b1; d_alu = ALU_PASS_A; d_imm = DATA_W'(dec_ir[7:0]); end
            OP_ST:   begin
                d_st = 1'b1; d_rt = dec_ir[10:8]; d_alu = ALU_PASS_A;
                d_imm = DATA_W'(dec_ir[7:0]);
            end
            OP_BZ:   begin d_bz = 1'b1; d_rs = dec_ir[10:8]; d_alu = ALU_PASS_A; end
            OP_BP:   begin d_bp = 1'b1; d_rs = dec_ir[10:8]; d_alu = ALU_PASS_A; end
            OP_JMP:  begin d_jmp = 1'b1; d_noreg = 1'b1; end
            OP_HALT: begin d_halt = 1'b1; d_noreg = 1'b1; end
            default: begin d_illegal = 1'b1; d_noreg = 1'b1; end
        endcase
        if (d_noreg) begin
            d_rd = 3'd0;
            d_rs = 3'd0;
            d_rt = 3'd0;
        end else begin
            d_rd = d_rd;
        end
    end

    // Next state, next pc and the registered-output values for the state being entered.
    always_comb begin
        next_state  = state;
        next_ir     = ir;
        next_take   = take;
        next_pc     = pc;
        n_req       = 1'b0;
        n_rf_write  = 1'b0;
        n_imm_sel   = 1'b0;
        n_mem_write = 1'b0;
        n_mem_sel   = 1'b0;
        n_halted    = 1'b0;
        n_illegal   = 1'b0;
        n_rs        = 3'd0;
        n_rt        = 3'd0;
        n_rd        = 3'd0;
        n_imm       = '0;
        n_alu       = 4'b0000;
        case (state)
            FETCH: begin
                if (instr_valid) begin
                    next_state = DECODE;
                    next_ir    = instr[15:0];
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE:  next_state = EXECUTE;
            EXECUTE: begin
                next_state = WRITEBACK;
                next_take  = (d_bz & zero_flag) | (d_bp & pos_flag) | d_jmp;
            end
            WRITEBACK: begin
                if (d_halt) begin
                    next_state = HALT;
                end else begin
                    next_state = FETCH;
                    next_pc    = pc + PC_W'(1'b1) + (take ? off_ext : '0);
                end
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
        case (next_state)
            FETCH:  n_req = 1'b1;
            DECODE, EXECUTE, WRITEBACK: begin
                n_rs      = d_rs;
                n_rt      = d_rt;
                n_rd      = d_rd;
                n_imm     = d_imm;
                n_imm_sel = d_imm_sel;
                n_illegal = (next_state == DECODE) & d_illegal;
                n_alu     = (next_state == DECODE) ? 4'b0000 : d_alu;
                n_mem_write = (next_state == EXECUTE) & d_st;
                n_rf_write  = (next_state == WRITEBACK) & d_wr;
                n_mem_sel   = (next_state == WRITEBACK) & d_ld;
            end
            HALT:    n_halted = 1'b1;
            default: n_req = 1'b0;
        endcase
    end

    // State, IR, pc and all output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            ir        <= 16'h0000;
            take      <= 1'b0;
            pc        <= '0;
            instr_req <= 1'b0;
            rf_write  <= 1'b0;
            rs_addr   <= 3'd0;
            rt_addr   <= 3'd0;
            rd_addr   <= 3'd0;
            imm_data  <= '0;
            alu_sel   <= 4'b0000;
            imm_sel   <= 1'b0;
            mem_write <= 1'b0;
            mem_sel   <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= next_state;
            ir        <= next_ir;
            take      <= next_take;
            pc        <= next_pc;
            instr_req <= n_req;
            rf_write  <= n_rf_write;
            rs_addr   <= n_rs;
            rt_addr   <= n_rt;
            rd_addr   <= n_rd;
            imm_data  <= n_imm;
            alu_sel   <= n_alu;
            imm_sel   <= n_imm_sel;
            mem_write <= n_mem_write;
            mem_sel   <= n_mem_sel;
            halted    <= n_halted;
            illegal   <= n_illegal;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit.
module tb_cpu_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        zero_flag = 1'b0;
    logic        pos_flag = 1'b0;
    logic        instr_req, rf_write, imm_sel, mem_write, mem_sel, halted, illegal;
    logic [7:0]  pc;
    logic [2:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm_data;
    logic [3:0]  alu_sel;

    int checks = 0;
    int errors = 0;

    cpu_control_unit #(.PC_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .zero_flag(zero_flag), .pos_flag(pos_flag), .instr_req(instr_req), .pc(pc),
        .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel), .mem_write(mem_write),
        .mem_sel(mem_sel), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a word with instr_valid for one edge; returns in DECODE.
    task automatic issue(input logic [15:0] word);
        instr = word;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if ({instr_req, rf_write, mem_write, halted, illegal, mem_sel, imm_sel} !== 7'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000000", {instr_req, rf_write, mem_write, halted, illegal, mem_sel, imm_sel}); end
        checks++; if ({pc, alu_sel, rd_addr, imm_data} !== 31'h0) begin errors++; $display("FAIL reset_fields got pc=%h alu=%b rd=%0d imm=%h exp 0", pc, alu_sel, rd_addr, imm_data); end
        reset = 1'b0;
        step();
        checks++; if (instr_req !== 1'b1 || pc !== 8'd0) begin errors++; $display("FAIL reset_release got req=%b pc=%h exp req=1 pc=00", instr_req, pc); end
    endtask

    task automatic test_movi_stall();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_req !== 1'b1 || pc !== 8'd0) begin errors++; $display("FAIL movi_stall got req=%b pc=%h exp req=1 pc=00", instr_req, pc); end
        end
        issue(16'hB708);
        checks++; if (rd_addr !== 3'd7 || imm_data !== 16'h0008 || imm_sel !== 1'b1 || instr_req !== 1'b0 || rf_write !== 1'b0) begin errors++; $display("FAIL movi_decode got rd=%0d imm=%h isel=%b req=%b rfw=%b exp 7 0008 1 0 0", rd_addr, imm_data, imm_sel, instr_req, rf_write); end
        step();
        checks++; if (alu_sel !== 4'b1011 || rf_write !== 1'b0) begin errors++; $display("FAIL movi_execute got alu=%b rfw=%b exp 1011 0", alu_sel, rf_write); end
        step();
        checks++; if (rf_write !== 1'b1 || mem_sel !== 1'b0 || pc !== 8'd0) begin errors++; $display("FAIL movi_writeback got rfw=%b msel=%b pc=%h exp 1 0 00", rf_write, mem_sel, pc); end
        step();
        checks++; if (rf_write !== 1'b0 || pc !== 8'd1 || instr_req !== 1'b1) begin errors++; $display("FAIL movi_done got rfw=%b pc=%h req=%b exp 0 01 1", rf_write, pc, instr_req); end
    endtask

    task automatic test_add_ld();
        issue(16'h094C);
        checks++; if (rs_addr !== 3'd2 || rt_addr !== 3'd3 || rd_addr !== 3'd1 || imm_sel !== 1'b0) begin errors++; $display("FAIL add_decode got rs=%0d rt=%0d rd=%0d isel=%b exp 2 3 1 0", rs_addr, rt_addr, rd_addr, imm_sel); end
        step();
        checks++; if (alu_sel !== 4'b0000 || rf_write !== 1'b0) begin errors++; $display("FAIL add_execute got alu=%b rfw=%b exp 0000 0", alu_sel, rf_write); end
        step();
        checks++; if (rf_write !== 1'b1 || mem_sel !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL add_writeback got rfw=%b msel=%b mw=%b exp 1 0 0", rf_write, mem_sel, mem_write); end
        step();
        issue(16'hC4A0);
        checks++; if (rs_addr !== 3'd5 || rd_addr !== 3'd4 || rf_write !== 1'b0 || mem_sel !== 1'b0) begin errors++; $display("FAIL ld_decode got rs=%0d rd=%0d rfw=%b msel=%b exp 5 4 0 0", rs_addr, rd_addr, rf_write, mem_sel); end
        step();
        checks++; if (rf_write !== 1'b0 || mem_sel !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL ld_execute got rfw=%b msel=%b mw=%b exp 0 0 0", rf_write, mem_sel, mem_write); end
        step();
        checks++; if (rf_write !== 1'b1 || mem_sel !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL ld_writeback got rfw=%b msel=%b mw=%b exp 1 1 0", rf_write, mem_sel, mem_write); end
        step();
        checks++; if (pc !== 8'd3 || rf_write !== 1'b0 || mem_sel !== 1'b0) begin errors++; $display("FAIL ld_done got pc=%h rfw=%b msel=%b exp 03 0 0", pc, rf_write, mem_sel); end
    endtask

    task automatic test_illegal();
        issue(16'h5000);
        checks++; if (illegal !== 1'b1 || rf_write !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL illegal_decode got ill=%b rfw=%b mw=%b exp 1 0 0", illegal, rf_write, mem_write); end
        step();
        checks++; if (illegal !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL illegal_execute got ill=%b mw=%b exp 0 0", illegal, mem_write); end
        step();
        checks++; if (illegal !== 1'b0 || rf_write !== 1'b0) begin errors++; $display("FAIL illegal_writeback got ill=%b rfw=%b exp 0 0", illegal, rf_write); end
        step();
        checks++; if (pc !== 8'd4) begin errors++; $display("FAIL illegal_pc got %h exp 04", pc); end
    endtask

    // Runs a branch/jump word from FETCH back to FETCH, checking no rf_write.
    task automatic run_branch(input logic [15:0] word, input logic z, input logic p, input logic [7:0] exp_pc);
        zero_flag = z;
        pos_flag = p;
        issue(word);
        step();
        checks++; if (alu_sel !== ((word[15:13] == 3'b111 && word[12:11] != 2'b10) ? 4'b1010 : 4'b0000) || rs_addr !== ((word[12:11] == 2'b10) ? 3'd0 : word[10:8])) begin errors++; $display("FAIL branch_execute %h got alu=%b rs=%0d", word, alu_sel, rs_addr); end
        step();
        checks++; if (rf_write !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL branch_writeback %h got rfw=%b mw=%b exp 0 0", word, rf_write, mem_write); end
        step();
        zero_flag = 1'b0;
        pos_flag = 1'b0;
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL branch_pc %h got %h exp %h", word, pc, exp_pc); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 6; i++) begin
            issue(16'h0000); step(); step(); step();
        end
        checks++; if (pc !== 8'd10) begin errors++; $display("FAIL nop_run_pc got %h exp 0a", pc); end
        run_branch(16'hE2FE, 1'b1, 1'b0, 8'd9);
        issue(16'h0000); step(); step(); step();
        run_branch(16'hE2FE, 1'b0, 1'b1, 8'd11);
        run_branch(16'hEA03, 1'b0, 1'b1, 8'd15);
    endtask

    task automatic test_jmp_wrap();
        run_branch(16'hF0EF, 1'b0, 1'b0, 8'd255);
        run_branch(16'hF001, 1'b0, 1'b0, 8'd1);
        run_branch(16'hF0FE, 1'b0, 1'b0, 8'd0);
        run_branch(16'hF0FF, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_st_reset();
        issue(16'hC800);
        step();
        checks++; if (mem_write !== 1'b1 || rf_write !== 1'b0) begin errors++; $display("FAIL st_execute got mw=%b rfw=%b exp 1 0", mem_write, rf_write); end
        #3 reset = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0 || pc !== 8'd0 || instr_req !== 1'b0) begin errors++; $display("FAIL st_reset got mw=%b pc=%h req=%b exp 0 00 0", mem_write, pc, instr_req); end
        step();
        reset = 1'b0;
        step();
        checks++; if (instr_req !== 1'b1 || mem_write !== 1'b0 || rf_write !== 1'b0) begin errors++; $display("FAIL st_refetch got req=%b mw=%b rfw=%b exp 1 0 0", instr_req, mem_write, rf_write); end
    endtask

    task automatic test_halt();
        issue(16'hF800);
        step(); step();
        checks++; if (halted !== 1'b0 || rf_write !== 1'b0) begin errors++; $display("FAIL halt_writeback got halted=%b rfw=%b exp 0 0", halted, rf_write); end
        instr = 16'h094C;
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (halted !== 1'b1 || instr_req !== 1'b0 || pc !== 8'd0 || rf_write !== 1'b0) begin errors++; $display("FAIL halt_hold cycle %0d got halted=%b req=%b pc=%h rfw=%b exp 1 0 00 0", i, halted, instr_req, pc, rf_write); end
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b exp 0", halted); end
        step();
        reset = 1'b0;
        step();
        checks++; if (instr_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_restart got req=%b halted=%b exp 1 0", instr_req, halted); end
    endtask

    initial begin
        test_reset();
        test_movi_stall();
        test_add_ld();
        test_illegal();
        test_branch();
        test_jmp_wrap();
        test_st_reset();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
